// File: rtl/data_mem_stage.sv
// Load/store stage over an internal word RAM; resp_valid WAIT_CYCLES+1 cycles after accept; req_ready only in IDLE, stall = req_valid & ~resp_valid.
// Optional MISALIGN_TRAP_EN: misaligned half/word accesses report resp_err instead of being force-aligned.
module data_mem_stage #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        stall
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  typedef struct packed {
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      state;
  logic [3:0]  cnt;
  req_t        held;
  req_t        cur;
  logic        commit;
  logic        legal;
  logic        err;
  logic [1:0]  lane;
  logic [AW-1:0] idx;
  logic [31:0] word;
  logic [31:0] shifted;
  logic [31:0] ld_data;
  logic [3:0]  be;
  logic [31:0] wd;
  logic        unused_addr;

  logic [31:0] mem [DEPTH_WORDS];

  // In IDLE the live inputs are decoded so a zero-wait access can commit on its accept edge.
  assign cur    = (state == S_IDLE) ? {req_we, req_funct3, req_addr, req_wdata} : held;
  assign commit = ((state == S_IDLE) && req_valid && (WAIT_CYCLES == 0)) ||
                  ((state == S_WAIT) && (cnt == 4'd1));

  assign idx         = cur.addr[AW+1:2];
  assign word        = mem[idx];
  assign unused_addr = ^cur.addr[31:AW+2];

  always_comb begin
    legal = 1'b0;
    err   = 1'b0;
    lane  = cur.addr[1:0];
    if (cur.we) legal = (cur.funct3 == 3'b000) || (cur.funct3 == 3'b001) || (cur.funct3 == 3'b010);
    else        legal = (cur.funct3 == 3'b000) || (cur.funct3 == 3'b001) || (cur.funct3 == 3'b010) ||
                        (cur.funct3 == 3'b100) || (cur.funct3 == 3'b101);
`ifdef MISALIGN_TRAP_EN
    err = ~legal |
          ((cur.funct3[1:0] == 2'd1) & cur.addr[0]) |
          ((cur.funct3[1:0] == 2'd2) & (|cur.addr[1:0]));
`else
    err = ~legal;
    if (cur.funct3[1:0] == 2'd2)      lane = 2'b00;
    else if (cur.funct3[1:0] == 2'd1) lane = {cur.addr[1], 1'b0};
`endif
  end

  always_comb begin
    be = 4'hf;
    wd = cur.wdata;
    case (cur.funct3[1:0])
      2'd0: begin
        be = 4'b0001 << lane;
        wd = {4{cur.wdata[7:0]}};
      end
      2'd1: begin
        be = 4'b0011 << lane;
        wd = {2{cur.wdata[15:0]}};
      end
      default: begin
        be = 4'hf;
        wd = cur.wdata;
      end
    endcase
  end

  assign shifted = word >> {lane, 3'b000};

  always_comb begin
    ld_data = 32'd0;
    case (cur.funct3)
      3'b000:  ld_data = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  ld_data = {{16{shifted[15]}}, shifted[15:0]};
      3'b010:  ld_data = shifted;
      3'b100:  ld_data = {24'd0, shifted[7:0]};
      3'b101:  ld_data = {16'd0, shifted[15:0]};
      default: ld_data = 32'd0;
    endcase
  end

  // RAM is not reset; rst_n gating keeps an access aborted by reset from ever writing.
  always_ff @(posedge clk) begin
    if (rst_n && commit && cur.we && !err) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wd[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= 4'd0;
      held       <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
    end else begin
      resp_valid <= commit;
      if (commit) begin
        resp_rdata <= (err || cur.we) ? 32'd0 : ld_data;
        resp_err   <= err;
      end
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            held  <= cur;
            cnt   <= WAIT_INIT;
            state <= (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
          end
        end
        S_WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= S_RESP;
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign req_ready = (state == S_IDLE);
  assign stall     = req_valid & ~resp_valid;

endmodule

// File: tb/tb_data_mem_stage.sv
// Drives a WAIT_CYCLES=1 and a WAIT_CYCLES=3 instance with identical requests against a byte-array model.
module tb_data_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        rdy1, rv1, er1, st1;
  logic [31:0] rd1;
  logic        rdy3, rv3, er3, st3;
  logic [31:0] rd3;

  int total = 0;
  int bad   = 0;

  logic [7:0] mb [4096];

  always #5 clk = ~clk;

  data_mem_stage #(.DEPTH_WORDS(1024), .WAIT_CYCLES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(rdy1), .resp_valid(rv1), .resp_rdata(rd1), .resp_err(er1), .stall(st1)
  );

  data_mem_stage #(.DEPTH_WORDS(1024), .WAIT_CYCLES(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(rdy3), .resp_valid(rv3), .resp_rdata(rd3), .resp_err(er3), .stall(st3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Little-endian byte memory of 4 KiB: byte address wraps modulo 4096.
  task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdat, output logic [31:0] rd, output logic er);
    int n;
    int base;
    logic [31:0] v;
    rd = 32'd0;
    er = 1'b0;
    n = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    if (f3[1:0] == 2'd3 || (f3[2] && (we || f3[1:0] == 2'd2))) begin
      er = 1'b1;
      return;
    end
    base = int'(addr % 32'd4096);
    if (base % n != 0) begin
`ifdef MISALIGN_TRAP_EN
      er = 1'b1;
      return;
`else
      base = base - (base % n);
`endif
    end
    if (we) begin
      for (int i = 0; i < n; i++) mb[base + i] = 8'(wdat >> (8 * i));
    end else begin
      v = 32'd0;
      for (int i = 0; i < n; i++) v = v | (32'(mb[base + i]) << (8 * i));
      if (!f3[2] && n < 4 && v[8 * n - 1]) v = v | (32'hFFFF_FFFF << (8 * n));
      rd = v;
    end
  endtask

  task automatic do_op(input string tag, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdat,
                       input bit use_exp, input logic [31:0] xr, input logic xe);
    logic [31:0] mr, r1, r3;
    logic me, e1, e3;
    int k1, k3, n1, n3;
    model(we, f3, addr, wdat, mr, me);
    if (use_exp) begin
      mr = xr;
      me = xe;
    end
    k1 = 0; k3 = 0; n1 = 0; n3 = 0;
    r1 = 'x; r3 = 'x; e1 = 'x; e3 = 'x;
    @(negedge clk);
    chk({tag, " ready1"}, 32'(rdy1), 32'd1);
    chk({tag, " ready3"}, 32'(rdy3), 32'd1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdat;
    #1;
    chk({tag, " stall_accept"}, 32'(st1), 32'd1);
    @(posedge clk);
    for (int k = 1; k <= 6; k++) begin
      #1;
      if (k == 1) chk({tag, " stall_wait"}, 32'(st1), 32'd1);
      if (rv1) begin
        n1++;
        if (k1 == 0) begin
          k1 = k; r1 = rd1; e1 = er1;
          chk({tag, " stall_resp"}, 32'(st1), 32'd0);
          req_valid = 1'b0;
        end
      end
      if (rv3) begin
        n3++;
        if (k3 == 0) begin
          k3 = k; r3 = rd3; e3 = er3;
        end
      end
      @(posedge clk);
    end
    req_valid = 1'b0;
    chk({tag, " lat1"}, 32'(k1), 32'd2);
    chk({tag, " lat3"}, 32'(k3), 32'd4);
    chk({tag, " pulses1"}, 32'(n1), 32'd1);
    chk({tag, " pulses3"}, 32'(n3), 32'd1);
    chk({tag, " rdata1"}, r1, mr);
    chk({tag, " err1"}, 32'(e1), 32'(me));
    chk({tag, " rdata3"}, r3, mr);
    chk({tag, " err3"}, 32'(e3), 32'(me));
  endtask

  initial begin
    logic [31:0] a;
    logic [2:0]  f;
    for (int i = 0; i < 4096; i++) mb[i] = 8'h00;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'd0; req_wdata = 32'd0;
    #1;
    chk("rst resp_valid1", 32'(rv1), 32'd0);
    chk("rst resp_rdata1", rd1, 32'd0);
    chk("rst resp_err1", 32'(er1), 32'd0);
    chk("rst ready1", 32'(rdy1), 32'd1);
    chk("rst resp_valid3", 32'(rv3), 32'd0);
    chk("rst resp_rdata3", rd3, 32'd0);
    chk("rst ready3", 32'(rdy3), 32'd1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    do_op("sw10", 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1, 32'h0, 1'b0);
    do_op("lw10", 1'b0, 3'b010, 32'h10, 32'h0, 1, 32'hDEADBEEF, 1'b0);
    do_op("lb13", 1'b0, 3'b000, 32'h13, 32'h0, 1, 32'hFFFFFFDE, 1'b0);
    do_op("lbu13", 1'b0, 3'b100, 32'h13, 32'h0, 1, 32'h000000DE, 1'b0);
    do_op("lh12", 1'b0, 3'b001, 32'h12, 32'h0, 1, 32'hFFFFDEAD, 1'b0);
    do_op("lhu10", 1'b0, 3'b101, 32'h10, 32'h0, 1, 32'h0000BEEF, 1'b0);
    // Lane 1 is bits 15:8, so SB 0x11 replaces the 0xBE byte of 0xDEADBEEF.
    do_op("sb11", 1'b1, 3'b000, 32'h11, 32'h000000AA, 1, 32'h0, 1'b0);
    do_op("lw10b", 1'b0, 3'b010, 32'h10, 32'h0, 1, 32'hDEADAAEF, 1'b0);
    do_op("sh12", 1'b1, 3'b001, 32'h12, 32'h00001234, 1, 32'h0, 1'b0);
    do_op("lw10c", 1'b0, 3'b010, 32'h10, 32'h0, 1, 32'h1234AAEF, 1'b0);
    do_op("sw1000", 1'b1, 3'b010, 32'h1000, 32'h55, 1, 32'h0, 1'b0);
    do_op("lw0wrap", 1'b0, 3'b010, 32'h0, 32'h0, 1, 32'h00000055, 1'b0);
`ifdef MISALIGN_TRAP_EN
    do_op("lw12mis", 1'b0, 3'b010, 32'h12, 32'h0, 1, 32'h0, 1'b1);
`else
    do_op("lw12mis", 1'b0, 3'b010, 32'h12, 32'h0, 1, 32'h1234AAEF, 1'b0);
`endif
    do_op("ld011", 1'b0, 3'b011, 32'h10, 32'h0, 1, 32'h0, 1'b1);
    do_op("sd011", 1'b1, 3'b011, 32'h10, 32'hFFFFFFFF, 1, 32'h0, 1'b1);
    do_op("su100", 1'b1, 3'b100, 32'h10, 32'hFFFFFFFF, 1, 32'h0, 1'b1);
    do_op("lw10d", 1'b0, 3'b010, 32'h10, 32'h0, 1, 32'h1234AAEF, 1'b0);

    do_op("sw20", 1'b1, 3'b010, 32'h20, 32'h11223344, 1, 32'h0, 1'b0);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h20; req_wdata = 32'hCAFEF00D;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("abort in_wait3", 32'(rdy3), 32'd0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort resp_valid1", 32'(rv1), 32'd0);
    chk("abort resp_valid3", 32'(rv3), 32'd0);
    chk("abort ready3", 32'(rdy3), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    do_op("lw20", 1'b0, 3'b010, 32'h20, 32'h0, 1, 32'h11223344, 1'b0);

    for (int w = 0; w < 8; w++) do_op("init", 1'b1, 3'b010, 32'(w * 4), $urandom, 0, 32'h0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      a = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 31));
      f = 3'($urandom_range(0, 7));
      do_op("rand", 1'($urandom_range(0, 1)), f, a, $urandom, 0, 32'h0, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
